// File: rtl/hazard_pkg.sv
// Shared encodings and FSM state type for the pipeline hazard controller.
package hazard_pkg;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_W   = 2'b01;
    localparam logic [1:0] FWD_M   = 2'b10;

    localparam int MC_CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mc_state_t;

endpackage

// File: rtl/hazard_mc_fsm.sv
// Multi-cycle execute sequencer: holds a mul/div op in E for MC_LAT cycles,
// freezing its progress while the data memory stalls the whole pipeline.
module hazard_mc_fsm
    import hazard_pkg::*;
#(
    parameter int MC_LAT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic mc_start,
    input  logic freeze,
    output logic mc_stall,
    output logic mc_busy
);

    localparam logic [MC_CNT_W-1:0] MC_LOAD = MC_CNT_W'(MC_LAT - 2);
    localparam mc_state_t START_NEXT = (MC_LAT == 2) ? DONE : BUSY;

    mc_state_t           stateReg;
    mc_state_t           stateNext;
    logic [MC_CNT_W-1:0] cntReg;
    logic [MC_CNT_W-1:0] cntNext;

    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg <= IDLE;
            cntReg   <= '0;
        end else begin
            stateReg <= stateNext;
            cntReg   <= cntNext;
        end
    end

    always_comb begin
        stateNext = stateReg;
        cntNext   = cntReg;
        mc_stall  = 1'b0;
        case (stateReg)
            IDLE: begin
                if (mc_start) begin
                    mc_stall = 1'b1;
                    if (!freeze) begin
                        cntNext   = MC_LOAD;
                        stateNext = START_NEXT;
                    end
                end
            end
            BUSY: begin
                mc_stall = 1'b1;
                if (!freeze) begin
                    cntNext = cntReg - 1'b1;
                    if (cntReg <= MC_CNT_W'(1)) begin
                        stateNext = DONE;
                    end
                end
            end
            // The op leaves E this cycle; its still-high start must not retrigger.
            DONE: begin
                if (!freeze) begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
                cntNext   = '0;
            end
        endcase
    end

    assign mc_busy = !rst && (stateReg != IDLE);

endmodule

// File: rtl/hazard_ctrl_mc.sv
// Five-stage pipeline hazard controller: operand forwarding, load-use,
// multi-cycle execute, memory wait and branch flush, plus perf counters.
module hazard_ctrl_mc
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int MC_LAT     = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] rs1_d,
    input  logic [REG_ADDR_W-1:0] rs2_d,
    input  logic [REG_ADDR_W-1:0] rs1_e,
    input  logic [REG_ADDR_W-1:0] rs2_e,
    input  logic [REG_ADDR_W-1:0] rd_e,
    input  logic [REG_ADDR_W-1:0] rd_m,
    input  logic [REG_ADDR_W-1:0] rd_w,
    input  logic                  regwrite_m,
    input  logic                  regwrite_w,
    input  logic                  load_e,
    input  logic                  mc_start_e,
    input  logic                  pcsrc_e,
    input  logic                  dmem_wait_m,
    output logic [1:0]            forward_a_e,
    output logic [1:0]            forward_b_e,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  stall_e,
    output logic                  stall_m,
    output logic                  flush_d,
    output logic                  flush_e,
    output logic                  flush_m,
    output logic                  flush_w,
    output logic                  mc_busy,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    logic [REG_ADDR_W-1:0] rsE [2];
    logic [1:0]            fwdSel [2];
    logic                  cntEvent [2];
    logic [CNT_W-1:0]      perfCnt [2];
    logic                  mcStall;
    logic                  loadUse;

    assign rsE[0] = rs1_e;
    assign rsE[1] = rs2_e;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            logic [1:0] sel;
            always_comb begin
                sel = FWD_REG;
                if (rst || rsE[gi] == '0) begin
                    sel = FWD_REG;
                end else if (regwrite_m && rsE[gi] == rd_m) begin
                    sel = FWD_M;
                end else if (regwrite_w && rsE[gi] == rd_w) begin
                    sel = FWD_W;
                end
            end
            assign fwdSel[gi] = sel;
        end
    endgenerate

    assign forward_a_e = fwdSel[0];
    assign forward_b_e = fwdSel[1];

    assign loadUse = load_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));

    hazard_mc_fsm #(
        .MC_LAT (MC_LAT)
    ) u_mc_fsm (
        .clk      (clk),
        .rst      (rst),
        .mc_start (mc_start_e),
        .freeze   (dmem_wait_m),
        .mc_stall (mcStall),
        .mc_busy  (mc_busy)
    );

    // A held E stage keeps a pending branch alive, so the memory wait may
    // safely swallow it and let it act once the wait clears.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_m = 1'b0;
        flush_w = 1'b0;
        if (rst) begin
            stall_f = 1'b0;
        end else if (dmem_wait_m) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
        end else if (mcStall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            flush_m = 1'b1;
        end else if (pcsrc_e) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (loadUse) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    assign cntEvent[0] = stall_f;
    assign cntEvent[1] = flush_d;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_perf
            logic [CNT_W-1:0] cntReg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    cntReg <= '0;
                end else if (cntEvent[gi] && (cntReg != {CNT_W{1'b1}})) begin
                    cntReg <= cntReg + 1'b1;
                end
            end
            assign perfCnt[gi] = cntReg;
        end
    endgenerate

    assign stall_cnt = perfCnt[0];
    assign flush_cnt = perfCnt[1];

endmodule

// File: doc/hazard_ctrl_mc.md
# hazard_ctrl_mc

Parametrised hazard controller for the five-stage RV32 pipeline. It replaces the fixed forward/stall/flush logic with one block that also handles a multi-cycle execute op (mul/div) through an internal FSM and a variable-latency data-memory wait. It sits beside the stage modules in the pipeline top and drives every stage's stall and flush enables. It also exports saturating stall and flush performance counters.

## Interface
Parameters:
- REG_ADDR_W, 5, register-index width.
- MC_LAT, 4, total cycles a multi-cycle op occupies E. Must be at least 2.
- CNT_W, 16, performance-counter width.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- rs1_d, rs2_d  in  REG_ADDR_W  source indices in D.
- rs1_e, rs2_e  in  REG_ADDR_W  source indices in E.
- rd_e, rd_m, rd_w  in  REG_ADDR_W  destination indices per stage.
- regwrite_m, regwrite_w  in  1  destination write enables.
- load_e  in  1  instruction in E is a load.
- mc_start_e  in  1  instruction in E is a multi-cycle op; held high while it sits in E.
- pcsrc_e  in  1  taken branch or jump resolved in E.
- dmem_wait_m  in  1  data memory not ready for the instruction in M.
- forward_a_e, forward_b_e  out  2  operand select: 00 register file, 01 W result, 10 M ALU result.
- stall_f, stall_d, stall_e, stall_m  out  1  hold the stage register.
- flush_d, flush_e, flush_m, flush_w  out  1  load a bubble into the stage register.
- mc_busy  out  1  FSM is not IDLE.
- stall_cnt, flush_cnt  out  CNT_W  performance counters.

## Operation
- **Forwarding (per E source, combinational).**
  - rs≠0 and rs==rd_m and regwrite_m → 10.
  - else rs≠0 and rs==rd_w and regwrite_w → 01.
  - else → 00.
  - M has priority over W.
- **Load-use.** Condition: load_e, rd_e≠0, and rd_e equals rs1_d or rs2_d. Response: stall_f=stall_d=1 and flush_e=1.
- **Multi-cycle FSM (states IDLE, BUSY, DONE; 3-bit down-counter).**
  - IDLE with mc_start_e: assert stall_f/d/e and flush_m; counter←MC_LAT-2. Next state is BUSY, or DONE if MC_LAT==2.
  - BUSY: same stalls and flush_m; counter decrements; go to DONE when counter reaches 1.
  - DONE: no stalls, so the op advances to M. Go to IDLE. mc_start_e is ignored in DONE so the same op cannot retrigger.
  - Result: the op occupies E for exactly MC_LAT cycles.
- **Memory wait.** dmem_wait_m asserts stall_f/d/e/m and flush_w. The FSM state and counter freeze.
- **Branch.** pcsrc_e asserts flush_d and flush_e.
- **Priority, highest first:**
  1. dmem_wait_m. All other stalls and flushes are suppressed except flush_w. pcsrc_e takes effect once the wait drops, because E is held.
  2. Multi-cycle stall. Load-use is suppressed and flush_e stays 0.
  3. pcsrc_e. Overrides load-use: stall_f/stall_d=0, flush_d=flush_e=1.
  4. Load-use.
- **Illegal input.** pcsrc_e together with mc_start_e is illegal; the bench asserts it never occurs.
- **Counters.**
  - stall_cnt increments on every cycle with stall_f=1.
  - flush_cnt increments on every cycle with flush_d=1.
  - Both saturate at all-ones and never wrap.

## Timing
- Forwarding, stall and flush outputs are combinational from the inputs, FSM state and counter: zero latency, same cycle.
- FSM, down-counter and performance counters are registered.
- While rst=1 all stall, flush and forward outputs are 0 and mc_busy=0.
- On the first edge with rst=1: state←IDLE, counter←0, stall_cnt←0, flush_cnt←0.
- Reset asserted mid-op aborts the FSM to IDLE. No residual stall appears after reset deasserts.
- Stall and flush counts reflect the previous cycle; the counter update is visible one cycle after the event.

## Structure
- Package hazard_pkg holds:
  - forward encodings FWD_REG=2'b00, FWD_W=2'b01, FWD_M=2'b10;
  - mc_state_t enum {IDLE, BUSY, DONE}.
- One sub-module, hazard_mc_fsm, containing the FSM, the down-counter and the freeze input. It outputs mc_stall and mc_busy.
- The top level holds forwarding, load-use detection, priority resolution and the counters.

## Test plan
- **Forwarding.** rs1_e=5, rd_m=5, regwrite_m=1, rd_w=5, regwrite_w=1 → forward_a_e=10. Then rd_m=0 → 01. Then rs1_e=0 → 00.
- **Load-use.** load_e=1, rd_e=7, rs2_d=7 → stall_f=stall_d=flush_e=1 for one cycle; stall_cnt advances by 1.
- **Multi-cycle, MC_LAT=4.** mc_start_e held high → stall_e=1 and flush_m=1 for 3 cycles, all stalls 0 in the 4th cycle, mc_busy high for cycles 2–4 after the trigger.
- **Memory wait during BUSY.** dmem_wait_m high for 2 cycles mid-op → stall_m=flush_w=1 for those 2 cycles; the op occupies E for MC_LAT+2 cycles.
- **Branch over load-use.** pcsrc_e=1 with load-use true → flush_d=flush_e=1, stall_f=stall_d=0; flush_cnt advances by 1.
- **Saturation and reset.** CNT_W=2, 5 stall cycles → stall_cnt=3. rst pulsed during BUSY → all outputs 0, counters 0, state IDLE on the next cycle.
